// File: rtl/awg_sweep_ctrl_if.sv
// Config write port of awg_sweep_ctrl: valid/ready handshake carrying a register address and data.
`timescale 1ns/1ps
interface awg_sweep_ctrl_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;

    modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);
endinterface

// File: rtl/awg_sweep_ctrl.sv
// Sweep sequencer for the sine DDS: config register file plus one-shot / repeat / triangle frequency sweeps.
// Define AWG_AMP_RAMP_EN to add the soft-start amplitude ramp (7 down to AMP at each dwell boundary).
`timescale 1ns/1ps
module awg_sweep_ctrl #(
    parameter int FREQ_W  = 12,
    parameter int AMP_W   = 3,
    parameter int PHASE_W = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    awg_sweep_ctrl_if.slave    cfg,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               sweep_done,
    output logic               en,
    output logic [FREQ_W-1:0]  state_freq,
    output logic [AMP_W-1:0]   state_amp,
    output logic [PHASE_W-1:0] state_phase
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] A_F_START = 3'd0;
    localparam logic [2:0] A_F_STOP  = 3'd1;
    localparam logic [2:0] A_F_STEP  = 3'd2;
    localparam logic [2:0] A_DWELL   = 3'd3;
    localparam logic [2:0] A_AMP     = 3'd4;
    localparam logic [2:0] A_PHASE   = 3'd5;
    localparam logic [2:0] A_MODE    = 3'd6;

    localparam logic [AMP_W-1:0]   AMP_ONE   = AMP_W'(1'b1);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1'b1);
`ifdef AWG_AMP_RAMP_EN
    localparam logic [AMP_W-1:0]   AMP_MAX   = {AMP_W{1'b1}};
`endif

    state_t               state_r;
    state_t               state_nxt_s;

    logic [FREQ_W-1:0]    f_start_r, f_stop_r, f_step_r;
    logic [DWELL_W-1:0]   dwell_r;
    logic [AMP_W-1:0]     amp_r;
    logic [PHASE_W-1:0]   phase_r;
    logic [1:0]           mode_r;

    // Sweep parameters frozen at start so idle-time writes only apply to the next sweep
    logic [FREQ_W-1:0]    run_start_r, run_stop_r, run_step_r;
    logic [DWELL_W-1:0]   run_dwell_r;
    logic [1:0]           run_mode_r;

    logic [DWELL_W-1:0]   dwell_cnt_r;
    logic                 dir_up_r;
    logic                 leg_fwd_r;
    logic                 en_r, busy_r, sweep_done_r;
    logic [FREQ_W-1:0]    state_freq_r;
    logic [AMP_W-1:0]     state_amp_r;
    logic [PHASE_W-1:0]   state_phase_r;

    logic                 wr_s;
    logic                 start_go_s;
    logic                 step_s;
    logic                 endpoint_s;
    logic [FREQ_W:0]      next_freq_s;
    logic [FREQ_W-1:0]    target_s;
    logic [AMP_W-1:0]     amp_wr_s;
    logic [AMP_W-1:0]     amp_live_s;
    logic [PHASE_W-1:0]   phase_live_s;
    logic [DWELL_W-1:0]   dwell_wr_s;

    function automatic logic [AMP_W-1:0] clamp_amp(input logic [AMP_W-1:0] v);
        return (v == {AMP_W{1'b0}}) ? AMP_ONE : v;
    endfunction

    function automatic logic [DWELL_W-1:0] clamp_dwell(input logic [DWELL_W-1:0] v);
        return (v == {DWELL_W{1'b0}}) ? DWELL_ONE : v;
    endfunction

    assign cfg.cfg_ready = (state_r == ST_RUN) ? ((cfg.cfg_addr == A_AMP) || (cfg.cfg_addr == A_PHASE)) : 1'b1;
    assign wr_s          = cfg.cfg_valid & cfg.cfg_ready;
    assign amp_wr_s      = clamp_amp(cfg.cfg_data[AMP_W-1:0]);
    assign dwell_wr_s    = clamp_dwell(cfg.cfg_data[DWELL_W-1:0]);
    assign amp_live_s    = (wr_s && (cfg.cfg_addr == A_AMP)) ? amp_wr_s : amp_r;
    assign phase_live_s  = (wr_s && (cfg.cfg_addr == A_PHASE)) ? cfg.cfg_data[PHASE_W-1:0] : phase_r;

    assign start_go_s    = (state_r == ST_IDLE) && start && !stop;
    assign step_s        = (state_r == ST_RUN) && (dwell_cnt_r == (run_dwell_r - DWELL_ONE));
    assign target_s      = leg_fwd_r ? run_stop_r : run_start_r;

    // Next frequency and endpoint test; the extra top bit flags carry on the way up, borrow on the way down
    always_comb begin
        next_freq_s = {(FREQ_W+1){1'b0}};
        endpoint_s  = 1'b0;
        if (dir_up_r) begin
            next_freq_s = {1'b0, state_freq_r} + {1'b0, run_step_r};
            endpoint_s  = next_freq_s[FREQ_W] || (next_freq_s[FREQ_W-1:0] > target_s);
        end else begin
            next_freq_s = {1'b0, state_freq_r} - {1'b0, run_step_r};
            endpoint_s  = next_freq_s[FREQ_W] || (next_freq_s[FREQ_W-1:0] < target_s);
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_go_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (step_s && endpoint_s && (run_mode_r == 2'b00)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Config register file; address 7 is accepted and dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_start_r <= {FREQ_W{1'b0}};
            f_stop_r  <= {FREQ_W{1'b0}};
            f_step_r  <= {FREQ_W{1'b0}};
            dwell_r   <= DWELL_ONE;
            amp_r     <= AMP_ONE;
            phase_r   <= {PHASE_W{1'b0}};
            mode_r    <= 2'b00;
        end else if (wr_s) begin
            case (cfg.cfg_addr)
                A_F_START: f_start_r <= cfg.cfg_data[FREQ_W-1:0];
                A_F_STOP:  f_stop_r  <= cfg.cfg_data[FREQ_W-1:0];
                A_F_STEP:  f_step_r  <= cfg.cfg_data[FREQ_W-1:0];
                A_DWELL:   dwell_r   <= dwell_wr_s;
                A_AMP:     amp_r     <= amp_wr_s;
                A_PHASE:   phase_r   <= cfg.cfg_data[PHASE_W-1:0];
                A_MODE:    mode_r    <= cfg.cfg_data[1:0];
                default:   mode_r    <= mode_r;
            endcase
        end
    end

    // Sweep datapath and registered DDS outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_start_r   <= {FREQ_W{1'b0}};
            run_stop_r    <= {FREQ_W{1'b0}};
            run_step_r    <= {FREQ_W{1'b0}};
            run_dwell_r   <= DWELL_ONE;
            run_mode_r    <= 2'b00;
            dwell_cnt_r   <= {DWELL_W{1'b0}};
            dir_up_r      <= 1'b1;
            leg_fwd_r     <= 1'b1;
            en_r          <= 1'b0;
            busy_r        <= 1'b0;
            sweep_done_r  <= 1'b0;
            state_freq_r  <= {FREQ_W{1'b0}};
            state_amp_r   <= AMP_ONE;
            state_phase_r <= {PHASE_W{1'b0}};
        end else begin
            en_r         <= (state_nxt_s == ST_RUN);
            busy_r       <= (state_nxt_s == ST_RUN);
            sweep_done_r <= (state_nxt_s == ST_DONE);
            if (start_go_s) begin
                run_start_r   <= f_start_r;
                run_stop_r    <= f_stop_r;
                run_step_r    <= f_step_r;
                run_dwell_r   <= dwell_r;
                run_mode_r    <= mode_r;
                dwell_cnt_r   <= {DWELL_W{1'b0}};
                dir_up_r      <= (f_stop_r >= f_start_r);
                leg_fwd_r     <= 1'b1;
                state_freq_r  <= f_start_r;
                state_phase_r <= phase_r;
`ifdef AWG_AMP_RAMP_EN
                state_amp_r   <= AMP_MAX;
`else
                state_amp_r   <= amp_r;
`endif
            end else if ((state_r == ST_RUN) && !stop) begin
                state_phase_r <= phase_live_s;
`ifdef AWG_AMP_RAMP_EN
                // A raised target jumps immediately; otherwise step down once per dwell boundary
                if (amp_live_s > state_amp_r) begin
                    state_amp_r <= amp_live_s;
                end else if (step_s && (state_amp_r > amp_live_s)) begin
                    state_amp_r <= state_amp_r - AMP_ONE;
                end
`else
                state_amp_r   <= amp_live_s;
`endif
                if (step_s) begin
                    dwell_cnt_r <= {DWELL_W{1'b0}};
                    if (!endpoint_s) begin
                        state_freq_r <= next_freq_s[FREQ_W-1:0];
                    end else if (run_mode_r[1]) begin
                        // Triangle turn-around: frequency holds for one extra dwell period
                        dir_up_r  <= !dir_up_r;
                        leg_fwd_r <= !leg_fwd_r;
                    end else if (run_mode_r[0]) begin
                        state_freq_r <= run_start_r;
                    end
                end else begin
                    dwell_cnt_r <= dwell_cnt_r + DWELL_ONE;
                end
            end
        end
    end

    assign en          = en_r;
    assign busy        = busy_r;
    assign sweep_done  = sweep_done_r;
    assign state_freq  = state_freq_r;
    assign state_amp   = state_amp_r;
    assign state_phase = state_phase_r;

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Self-checking bench for awg_sweep_ctrl: directed vector table, hand-written corner sequences and
// randomized sweeps compared against an arithmetic model of the sweep sequence.
`timescale 1ns/1ps
module tb_awg_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        busy;
    logic        sweep_done;
    logic        en;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;

    awg_sweep_ctrl_if cfg_bus();

    awg_sweep_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg         (cfg_bus),
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .en          (en),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int fs, fe, fd, dw, md;
        int nvals;
        int ends;
        int seq [8];
    } vec_t;

    typedef struct {
        int addr, data, exp_ready, exp_amp, exp_phase;
    } gate_t;

    vec_t  vecs  [8];
    gate_t gates [9];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_addr  = addr[2:0];
        cfg_bus.cfg_data  = data[15:0];
        tick();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    // Program all registers; bits above each register's width carry junk that must be ignored
    task automatic setup(input int fs, input int fe, input int fd, input int dw, input int md,
                         input int amp, input int ph);
        int junk;
        junk = $urandom;
        cfg_write(0, (junk & 32'hF000) | fs);
        cfg_write(1, (junk & 32'hF000) | fe);
        cfg_write(2, (junk & 32'hF000) | fd);
        cfg_write(3, dw);
        cfg_write(4, (junk & 32'hFFF8) | amp);
        cfg_write(5, (junk & 32'hFF00) | ph);
        cfg_write(6, (junk & 32'hFFFC) | md);
    endtask

    task automatic start_sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop  = 1'b0;
    endtask

    // Frequency list L = fs, fs+-fd, ... not beyond fe; one-shot walks L once, repeat loops L,
    // triangle plays L then L reversed (turn points appear twice).
    function automatic int seq_len(input int fs, input int fe, input int fd);
        int span;
        span = (fe >= fs) ? (fe - fs) : (fs - fe);
        return span / fd + 1;
    endfunction

    function automatic int model_freq(input int fs, input int fe, input int fd, input int dw,
                                      input int md, input int t);
        int n, k, p, idx;
        if (fd == 0) return fs;
        n = seq_len(fs, fe, fd);
        k = t / dw;
        if ((md & 2) != 0) begin
            p   = k % (2 * n);
            idx = (p < n) ? p : (2 * n - 1 - p);
        end else if ((md & 1) != 0) begin
            idx = k % n;
        end else begin
            idx = (k < n) ? k : (n - 1);
        end
        return (fe >= fs) ? (fs + idx * fd) : (fs - idx * fd);
    endfunction

    function automatic int model_amp(input int amp, input int dw, input int t);
`ifdef AWG_AMP_RAMP_EN
        int r;
        r = 7 - t / dw;
        return (r > amp) ? r : amp;
`else
        return amp + 0 * (dw + t);
`endif
    endfunction

    initial begin
        rst_n             = 1'b0;
        start             = 1'b0;
        stop              = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_addr  = 3'd0;
        cfg_bus.cfg_data  = 16'd0;

        vecs[0] = '{100, 130, 10, 4, 0, 4, 1, '{100, 110, 120, 130, 0, 0, 0, 0}};
        vecs[1] = '{4000, 4095, 50, 1, 0, 2, 1, '{4000, 4050, 0, 0, 0, 0, 0, 0}};
        vecs[2] = '{4000, 4095, 50, 1, 1, 6, 0, '{4000, 4050, 4000, 4050, 4000, 4050, 0, 0}};
        vecs[3] = '{10, 30, 10, 2, 2, 8, 0, '{10, 20, 30, 30, 20, 10, 10, 20}};
        vecs[4] = '{200, 170, 10, 2, 0, 4, 1, '{200, 190, 180, 170, 0, 0, 0, 0}};
        vecs[5] = '{50, 50, 5, 1, 0, 1, 1, '{50, 0, 0, 0, 0, 0, 0, 0}};
        vecs[6] = '{77, 90, 0, 1, 0, 8, 0, '{77, 77, 77, 77, 77, 77, 77, 77}};
        vecs[7] = '{30, 10, 7, 1, 2, 8, 0, '{30, 23, 16, 16, 23, 30, 30, 23}};

        gates[0] = '{0, 555, 0, 5, 9};
        gates[1] = '{1, 555, 0, 5, 9};
        gates[2] = '{2, 1, 0, 5, 9};
        gates[3] = '{3, 7, 0, 5, 9};
        gates[4] = '{4, 0, 1, 1, 9};
        gates[5] = '{5, 128, 1, 1, 128};
        gates[6] = '{6, 3, 0, 1, 128};
        gates[7] = '{7, 99, 0, 1, 128};
        gates[8] = '{4, 16'hFFF6, 1, 6, 128};

        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_en", en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", sweep_done, 0);
        check("rst_freq", state_freq, 0);
        check("rst_amp", state_amp, 1);
        check("rst_phase", state_phase, 0);

        // Directed sweep vectors
        for (int v = 0; v < 8; v++) begin
            setup(vecs[v].fs, vecs[v].fe, vecs[v].fd, vecs[v].dw, vecs[v].md, 3, v * 16 + 1);
            start_sweep();
            check($sformatf("vec%0d_amp", v), state_amp, model_amp(3, vecs[v].dw, 0));
            check($sformatf("vec%0d_phase", v), state_phase, v * 16 + 1);
            for (int t = 0; t < vecs[v].nvals * vecs[v].dw; t++) begin
                check($sformatf("vec%0d_freq_t%0d", v, t), state_freq, vecs[v].seq[t / vecs[v].dw]);
                check($sformatf("vec%0d_en_t%0d", v, t), en, 1);
                check($sformatf("vec%0d_done_t%0d", v, t), sweep_done, 0);
                tick();
            end
            if (vecs[v].ends != 0) begin
                check($sformatf("vec%0d_done_pulse", v), sweep_done, 1);
                check($sformatf("vec%0d_done_en", v), en, 0);
                check($sformatf("vec%0d_done_busy", v), busy, 0);
                check($sformatf("vec%0d_done_hold", v), state_freq, vecs[v].seq[vecs[v].nvals - 1]);
                tick();
                check($sformatf("vec%0d_done_clear", v), sweep_done, 0);
                check($sformatf("vec%0d_after_en", v), en, 0);
            end else begin
                do_stop();
                check($sformatf("vec%0d_stop_en", v), en, 0);
                check($sformatf("vec%0d_stop_busy", v), busy, 0);
                check($sformatf("vec%0d_stop_done", v), sweep_done, 0);
                tick();
                check($sformatf("vec%0d_stop_done2", v), sweep_done, 0);
            end
        end

        // Config gating and live AMP/PHASE while a continuous tone runs
        setup(77, 90, 0, 1, 0, 5, 9);
        start_sweep();
        for (int t = 0; t < 4; t++) tick();
        for (int g = 0; g < 9; g++) begin
            cfg_bus.cfg_valid = 1'b1;
            cfg_bus.cfg_addr  = gates[g].addr[2:0];
            cfg_bus.cfg_data  = gates[g].data[15:0];
            #1;
            check($sformatf("gate%0d_ready", g), cfg_bus.cfg_ready, gates[g].exp_ready);
            @(posedge clk);
            #1;
`ifndef AWG_AMP_RAMP_EN
            check($sformatf("gate%0d_amp", g), state_amp, gates[g].exp_amp);
`endif
            check($sformatf("gate%0d_phase", g), state_phase, gates[g].exp_phase);
            check($sformatf("gate%0d_freq", g), state_freq, 77);
        end
        cfg_bus.cfg_valid = 1'b0;
        // start while busy is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_busy", busy, 1);
        do_stop();
        start_sweep();
        check("gated_fstart_kept", state_freq, 77);
        do_stop();

        // Stop wins over start in the same cycle
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("prio_en", en, 0);
        check("prio_busy", busy, 0);

        // A write in the start cycle applies only from the next start
        cfg_write(0, 100);
        start             = 1'b1;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_addr  = 3'd0;
        cfg_bus.cfg_data  = 16'd500;
        tick();
        start             = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        check("startwr_old", state_freq, 100);
        do_stop();
        start_sweep();
        check("startwr_new", state_freq, 500);
        do_stop();

        // Asynchronous reset mid-sweep clears outputs and the register file
        setup(100, 130, 10, 4, 0, 5, 9);
        start_sweep();
        for (int t = 0; t < 6; t++) tick();
        rst_n = 1'b0;
        #1;
        check("arst_en", en, 0);
        check("arst_busy", busy, 0);
        check("arst_freq", state_freq, 0);
        check("arst_amp", state_amp, 1);
        check("arst_phase", state_phase, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        start_sweep();
        check("arst_restart_en", en, 1);
        check("arst_restart_freq", state_freq, 0);
        check("arst_restart_amp", state_amp, model_amp(1, 1, 0));
        check("arst_restart_phase", state_phase, 0);
        tick();
        tick();
        check("arst_restart_tone", state_freq, 0);
        do_stop();

`ifdef AWG_AMP_RAMP_EN
        setup(0, 1000, 1, 3, 0, 2, 0);
        start_sweep();
        for (int t = 0; t < 24; t++) begin
            check($sformatf("ramp_amp_t%0d", t), state_amp, model_amp(2, 3, t));
            tick();
        end
        do_stop();
`endif

        // Randomized sweeps against the arithmetic model, with start pulses while busy
        for (int it = 0; it < 20; it++) begin
            int fs, fe, fd, dw, md, amp, ph, span, dwe, ampe, done_t, win;
            fs   = $urandom_range(0, 4095);
            span = $urandom_range(0, 120);
            if ($urandom_range(0, 1) == 1) fe = (fs + span > 4095) ? 4095 : fs + span;
            else                           fe = (fs - span < 0) ? 0 : fs - span;
            fd   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            dw   = $urandom_range(0, 4);
            md   = $urandom_range(0, 3);
            amp  = $urandom_range(0, 7);
            ph   = $urandom_range(0, 255);
            dwe  = (dw == 0) ? 1 : dw;
            ampe = (amp == 0) ? 1 : amp;
            done_t = (md == 0 && fd != 0) ? seq_len(fs, fe, fd) * dwe : -1;
            win    = (done_t >= 0) ? done_t : 48;
            setup(fs, fe, fd, dw, md, amp, ph);
            start_sweep();
            for (int t = 0; t < win; t++) begin
                check($sformatf("rnd%0d_freq_t%0d", it, t), state_freq, model_freq(fs, fe, fd, dwe, md, t));
                check($sformatf("rnd%0d_amp_t%0d", it, t), state_amp, model_amp(ampe, dwe, t));
                check($sformatf("rnd%0d_phase_t%0d", it, t), state_phase, ph);
                check($sformatf("rnd%0d_en_t%0d", it, t), en, 1);
                check($sformatf("rnd%0d_done_t%0d", it, t), sweep_done, 0);
                start = ($urandom_range(0, 3) == 0);
                tick();
            end
            start = 1'b0;
            if (done_t >= 0) begin
                check($sformatf("rnd%0d_done_pulse", it), sweep_done, 1);
                check($sformatf("rnd%0d_done_en", it), en, 0);
                check($sformatf("rnd%0d_done_hold", it), state_freq, model_freq(fs, fe, fd, dwe, md, done_t));
                tick();
                check($sformatf("rnd%0d_done_clear", it), sweep_done, 0);
            end else begin
                do_stop();
                check($sformatf("rnd%0d_stop_en", it), en, 0);
                check($sformatf("rnd%0d_stop_busy", it), busy, 0);
                check($sformatf("rnd%0d_stop_done", it), sweep_done, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
